// File: rtl/upsample_2x_stream.sv
// 2x2 nearest-neighbour upsampler: each pooled sample becomes a 2x2 block, odd rows replayed from a row buffer.
// Optional UPSAMPLE_BACKPRESSURE_EN adds out_ready; a stalled output freezes all outputs and state.
module upsample_2x_stream #(
    parameter int data_width = 32,
    parameter int width      = 4,
    parameter int height     = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [data_width-1:0] data_in,
    input  logic                  valid_in,
`ifdef UPSAMPLE_BACKPRESSURE_EN
    input  logic                  out_ready,
`endif
    output logic                  in_ready,
    output logic [data_width-1:0] data_out,
    output logic                  valid_out,
    output logic                  row_end,
    output logic                  frame_end
);

    localparam int HALF_W = width / 2;
    localparam int CW     = (HALF_W > 1) ? $clog2(HALF_W) : 1;
    localparam int RW     = $clog2(height);

    typedef enum logic {ROW_A, ROW_B} state_t;

    state_t                state;
    logic [CW-1:0]         col;
    logic                  phase;
    logic [RW-1:0]         row;
    logic [data_width-1:0] line_buf [HALF_W];
    logic                  stall;
    logic                  last_col;
    logic                  xfer;

`ifdef UPSAMPLE_BACKPRESSURE_EN
    assign stall = valid_out && !out_ready;
`else
    assign stall = 1'b0;
`endif

    assign last_col = (col == CW'(HALF_W - 1));
    assign in_ready = (state == ROW_A) && !phase && !stall;
    assign xfer     = in_ready && valid_in;

    // Row buffer is deliberately left out of reset; only ROW_A writes it before ROW_B reads it.
    always_ff @(posedge clk) begin
        if (xfer) begin
            line_buf[col] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ROW_A;
            col       <= '0;
            phase     <= 1'b0;
            row       <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            row_end   <= 1'b0;
            frame_end <= 1'b0;
        end else if (!stall) begin
            valid_out <= 1'b0;
            row_end   <= 1'b0;
            frame_end <= 1'b0;
            case (state)
                ROW_A: begin
                    if (!phase) begin
                        if (valid_in) begin
                            data_out  <= data_in;
                            valid_out <= 1'b1;
                            phase     <= 1'b1;
                        end
                    end else begin
                        // Second copy: data_out still holds the sample from the previous cycle.
                        valid_out <= 1'b1;
                        phase     <= 1'b0;
                        if (last_col) begin
                            col     <= '0;
                            row_end <= 1'b1;
                            row     <= row + RW'(1);
                            state   <= ROW_B;
                        end else begin
                            col <= col + CW'(1);
                        end
                    end
                end
                ROW_B: begin
                    data_out  <= line_buf[col];
                    valid_out <= 1'b1;
                    phase     <= ~phase;
                    if (phase) begin
                        if (last_col) begin
                            col     <= '0;
                            row_end <= 1'b1;
                            state   <= ROW_A;
                            if (row == RW'(height - 1)) begin
                                frame_end <= 1'b1;
                                row       <= '0;
                            end else begin
                                row <= row + RW'(1);
                            end
                        end else begin
                            col <= col + CW'(1);
                        end
                    end
                end
                default: state <= ROW_A;
            endcase
        end
    end

endmodule

// File: doc/upsample_2x_stream.md
Name: upsample_2x_stream

Overview:
- Inverse of the 2x2/stride-2 max-pooling stage: 2x2 nearest-neighbour upsampler (unpool) on a raster pixel stream.
- Accepts one pooled sample per handshake and emits each sample as a 2x2 block in raster order.
  - Output row 2r repeats each sample twice.
  - Output row 2r+1 replays row 2r from an internal row buffer.
- Sits on the decoder/expansion side of the CNN datapath, fed by the same valid-qualified data bus the pooling stage drives.

Parameters:
- data_width, 32, bit width of one sample.
- width, 4, output row width in pixels; must be even and >= 2. Input row width is width/2.
- height, 4, output rows per frame; must be even and >= 2.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- data_in  input  data_width  pooled sample.
- valid_in  input  1  data_in valid.
- in_ready  output  1  block can accept data_in this cycle. Transfer occurs when valid_in && in_ready.
- data_out  output  data_width  upsampled pixel (registered).
- valid_out  output  1  data_out valid (registered).
- row_end  output  1  high with the last pixel of each output row.
- frame_end  output  1  high with the last pixel of the frame.

Behaviour:
- Reset (reset=0, asynchronous):
  - data_out=0, valid_out=0, row_end=0, frame_end=0.
  - State=ROW_A; col=0, phase=0, row=0.
  - Row buffer contents are not cleared.
- State registers:
  - col: 0..width/2-1.
  - phase: 0/1, duplicate index.
  - row: 0..height-1, output row index.
- State ROW_A (even output row):
  - in_ready = (phase==0), combinational from state.
  - phase=0 with transfer:
    - data_out<=data_in, valid_out<=1.
    - buf[col]<=data_in, phase<=1.
  - phase=0 without transfer: valid_out<=0, no state change.
  - phase=1 (in_ready=0):
    - data_out held, valid_out<=1, phase<=0.
    - If col==width/2-1: col<=0, row_end<=1, row<=row+1, state<=ROW_B.
    - Otherwise col<=col+1.
- State ROW_B (odd output row):
  - in_ready=0; input is never consumed.
  - Every cycle: data_out<=buf[col], valid_out<=1, phase toggles.
  - col increments after phase 1.
  - Last pixel (col==width/2-1, phase 1):
    - row_end<=1, col<=0, state<=ROW_A.
    - If row==height-1: frame_end<=1, row<=0. Otherwise row<=row+1.
- Outputs:
  - row_end and frame_end are single-cycle and coincide with the corresponding valid_out.
  - All outputs are otherwise 0.
- Latency: first copy of a sample appears 1 cycle after its transfer; second copy the following cycle.
- Throughput:
  - Input: at most 1 sample per 2 cycles during ROW_A; 0 during ROW_B.
  - Output: 1 pixel/cycle except ROW_A stalls waiting on valid_in.
- Handshake rules:
  - Upstream holds data_in/valid_in stable until transfer.
  - valid_in while in_ready=0 has no effect.
  - in_ready does not depend on valid_in.
- Reset mid-row or mid-frame: all state restarts at ROW_A col 0. Partially emitted rows are abandoned; the next transfer starts a new frame.
- Buffer write and ROW_B read never target the same address in the same cycle.

Optional Feature:
- Macro: UPSAMPLE_BACKPRESSURE_EN.
- Defined:
  - Adds input port out_ready (1 bit).
  - When valid_out && !out_ready: data_out, valid_out, row_end, frame_end and all state registers hold; in_ready=0.
  - When valid_out=0, out_ready is ignored.
  - No pixel is dropped or duplicated under any out_ready pattern.
- Undefined:
  - Port absent; the downstream sink is always ready.
  - Behaviour exactly as above.

Test Plan:
- Basic frame (width=4, height=4): feed 1,2,3,4 with valid_in constant 1 -> output sequence 1,1,2,2,1,1,2,2,3,3,4,4,3,3,4,4.
  - row_end on pixels 4, 8, 12, 16; frame_end only on pixel 16.
- Input gaps: same data, valid_in low 3 cycles before each sample -> identical output sequence.
  - in_ready=0 throughout both ROW_B rows.
  - No valid_out bubbles inside ROW_B.
- in_ready honour: hold valid_in=1 with data changing every cycle -> only values present on in_ready=1 cycles appear, each exactly 4 times in 2x2 layout.
- Reset mid-frame: assert reset after output pixel 6 -> outputs 0 immediately.
  - After release, feeding 9,8,7,6 -> 9,9,8,8,9,9,8,8,7,7,6,6,7,7,6,6.
- Back-to-back frames: 8 samples 1..8 -> two full frames, frame_end twice, no gap cycle between frames beyond input timing.
- UPSAMPLE_BACKPRESSURE_EN: toggle out_ready pseudo-randomly during the basic frame -> accepted-output sequence identical to the basic frame; data_out stable while stalled.
